// File: rtl/ddr2_chk_pkg.sv
// ddr2_chk_pkg: shared state encoding, counter widths and the read-pattern helper.
package ddr2_chk_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_GAP} state_t;
    localparam int ERR_CNT_W   = 16;
    localparam int BURST_CNT_W = 16;
    // The writer stores k+1 at word address 2k.
    function automatic logic [31:0] exp_of(input logic [31:0] addr);
        return (addr >> 1) + 32'd1;
    endfunction
endpackage

// File: rtl/ddr2_chk_cmp.sv
// ddr2_chk_cmp: per-beat data compare with saturating error count and first-error capture.
module ddr2_chk_cmp
    import ddr2_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] exp_val,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  mism,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [31:0]           beat_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    assign mism = beat && data != exp_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            if (beat) beat_cnt <= beat_cnt + 32'd1;
            if (mism) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                // err_cnt never returns to zero, so zero means no error seen yet
                if (err_cnt == '0) begin
                    first_err_addr <= addr;
                    first_err_data <= data;
                end
            end
        end
    end
endmodule

// File: rtl/ddr2_rd_checker.sv
// ddr2_rd_checker: read-traffic generator for axi_rd_master that checks returned
// beats against the incrementing write pattern and keeps sticky error status.
module ddr2_rd_checker
    import ddr2_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LEN     = 128,
    parameter int GAP_CYCLES = 150,
    parameter int TIMEOUT    = 4096,
    parameter int ADDR_LIMIT = 2**26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_end,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic                   rd_trig,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [7:0]             rd_len,
    input  logic                   rd_ready,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_data_en,
    input  logic                   rd_done,
    output logic                   err_flag,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [31:0]            beat_cnt,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic [ADDR_WIDTH-1:0]  first_err_addr,
    output logic [DATA_WIDTH-1:0]  first_err_data,
    output logic                   timeout
);
    localparam int STEP = 2 * RD_LEN;
    localparam int CMAX = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int AW1  = ADDR_WIDTH + 1;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [15:0]           beat_idx;
    logic [DATA_WIDTH-1:0] exp_val;
    logic                  wrapped;
    logic                  beat, accept, done, to_hit, len_bad, mism, wrap, gate_ok;
    logic [AW1-1:0]        nxt_addr;
    logic [ADDR_WIDTH-1:0] adv_addr;

    assign beat     = state == S_DATA && rd_data_en;
    assign done     = state == S_DATA && rd_done;
    assign accept   = state == S_REQ && rd_trig && rd_ready;
    assign to_hit   = (state == S_REQ || state == S_DATA) && cnt == CW'(TIMEOUT - 1)
                      && !accept && !done && !beat;
    assign len_bad  = done && (beat_idx + 16'(beat)) != 16'(RD_LEN);
    assign nxt_addr = {1'b0, rd_addr} + AW1'(STEP);
    assign wrap     = nxt_addr >= AW1'(ADDR_LIMIT);
    assign adv_addr = wrap ? '0 : nxt_addr[ADDR_WIDTH-1:0];
    // Read-behind-write gating is only meaningful until the reader first wraps.
    assign gate_ok  = wrapped || nxt_addr <= {1'b0, wr_addr};
    assign rd_len   = 8'(RD_LEN);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = init_end && enable && gate_ok ? S_REQ : S_IDLE;
            S_REQ:   state_nx = accept ? S_DATA : to_hit ? S_GAP : S_REQ;
            S_DATA:  state_nx = done || to_hit ? S_GAP : S_DATA;
            S_GAP:   state_nx = cnt == CW'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            beat_idx  <= '0;
            exp_val   <= DATA_WIDTH'(1);
            wrapped   <= 1'b0;
            rd_trig   <= 1'b0;
            rd_addr   <= '0;
            err_flag  <= 1'b0;
            timeout   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state   <= state_nx;
            rd_trig <= state_nx == S_REQ;
            cnt     <= state_nx != state || beat ? '0 : cnt + 1'b1;
            if (state == S_IDLE && state_nx == S_REQ) beat_idx <= '0;
            else if (beat) beat_idx <= beat_idx + 16'd1;
            if (beat) exp_val <= exp_val + 1'b1;
            // Resync the expected value at each burst boundary so one bad burst
            // does not cascade into every following one.
            if (done) begin
                rd_addr <= adv_addr;
                exp_val <= DATA_WIDTH'(exp_of(32'(adv_addr)));
                if (wrap) wrapped <= 1'b1;
            end
            if (to_hit) begin
                exp_val <= DATA_WIDTH'(exp_of(32'(rd_addr)));
                timeout <= 1'b1;
            end
            if (mism || len_bad || to_hit) err_flag <= 1'b1;
            if (done && !len_bad) burst_cnt <= burst_cnt + 1'b1;
        end
    end

    ddr2_chk_cmp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .beat           (beat),
        .data           (rd_data),
        .exp_val        (exp_val),
        .addr           (rd_addr + ADDR_WIDTH'({beat_idx, 1'b0})),
        .mism           (mism),
        .err_cnt        (err_cnt),
        .beat_cnt       (beat_cnt),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );
endmodule

// File: tb/tb_ddr2_rd_checker.sv
// tb_ddr2_rd_checker: randomized memory-side model feeding the read checker, scored
// against the write pattern (word 2k holds k+1) and the burst/address rules.
module tb_ddr2_rd_checker;
    localparam int RD_LEN  = 128;
    localparam int GAP     = 12;
    localparam int TMO     = 600;
    localparam int LIMIT   = 1024;

    logic        clk = 0, rst_n = 0, init_end = 0, enable = 0;
    logic [25:0] wr_addr = '0;
    logic        rd_trig, rd_ready = 0, rd_data_en = 0, rd_done = 0;
    logic [25:0] rd_addr, first_err_addr;
    logic [7:0]  rd_len;
    logic [31:0] rd_data = '0, beat_cnt, first_err_data;
    logic        err_flag, timeout;
    logic [15:0] err_cnt, burst_cnt;

    int errors = 0, checks = 0;
    int m_addr, m_beats, m_err, m_bursts;
    bit m_errflag;
    logic [25:0] m_first_addr;
    logic [31:0] m_first_data;
    logic [31:0] corrupt [int];

    always #5 clk = ~clk;

    ddr2_rd_checker #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .RD_LEN(RD_LEN), .GAP_CYCLES(GAP),
                      .TIMEOUT(TMO), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end), .enable(enable), .wr_addr(wr_addr),
        .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_done(rd_done), .err_flag(err_flag),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt), .burst_cnt(burst_cnt),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data), .timeout(timeout)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 0; rd_ready = 0; rd_data_en = 0; rd_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_addr = 0; m_beats = 0; m_err = 0; m_bursts = 0; m_errflag = 0;
        m_first_addr = '0; m_first_data = '0;
        corrupt.delete();
    endtask

    // Memory-side model: accept one request, return nbeats, update the scoreboard.
    task automatic serve(input int nbeats, input bit done_last, output logic [25:0] a, output bit got);
        int w;
        logic [31:0] d;
        got = 0; a = '0;
        for (int i = 0; i < 400 && !got; i++) if (rd_trig) got = 1; else @(negedge clk);
        if (!got) return;
        a = rd_addr;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rd_ready = 1; @(negedge clk); rd_ready = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < nbeats; i++) begin
            w = int'(a) + 2 * i;
            d = corrupt.exists(w) ? corrupt[w] : 32'(w / 2 + 1);
            rd_data = d; rd_data_en = 1; rd_done = done_last && i == nbeats - 1;
            @(negedge clk);
            rd_data_en = 0; rd_done = 0;
            if (d !== 32'(w / 2 + 1)) begin
                if (m_err == 0) begin m_first_addr = 26'(w); m_first_data = d; end
                m_err++; m_errflag = 1;
            end
            m_beats++;
            if (i < nbeats - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
        end
        if (!done_last) begin rd_done = 1; @(negedge clk); rd_done = 0; end
        if (nbeats == RD_LEN) m_bursts++; else m_errflag = 1;
        m_addr = int'(a) + 2 * RD_LEN >= LIMIT ? 0 : int'(a) + 2 * RD_LEN;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%0b want=0", rd_trig); end
        checks++; if (rd_addr !== 26'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", rd_addr); end
        checks++; if ({err_flag, timeout, err_cnt, burst_cnt} !== '0) begin errors++; $display("FAIL reset_flags got=%0h want=0", {err_flag, timeout, err_cnt, burst_cnt}); end
        checks++; if ({beat_cnt, first_err_addr, first_err_data} !== '0) begin errors++; $display("FAIL reset_cnt got=%0h want=0", {beat_cnt, first_err_addr, first_err_data}); end
        checks++; if (rd_len !== 8'(RD_LEN)) begin errors++; $display("FAIL rd_len got=%0d want=%0d", rd_len, RD_LEN); end
        enable = 1; wr_addr = '1;
        begin
            bit saw = 0;
            repeat (20) begin @(negedge clk); if (rd_trig) saw = 1; end
            checks++; if (saw) begin errors++; $display("FAIL init_gate got=trig want=no trig"); end
        end
    endtask

    task automatic test_gating_clean();
        logic [25:0] a;
        bit got, saw = 0;
        int n = 0;
        do_reset();
        init_end = 1; enable = 1; wr_addr = 26'd200;
        repeat (40) begin @(negedge clk); if (rd_trig) saw = 1; end
        checks++; if (saw) begin errors++; $display("FAIL gate_hold got=trig want=no trig"); end
        wr_addr = 26'd256;
        while (!rd_trig && n < 2) begin @(negedge clk); n++; end
        checks++; if (!rd_trig) begin errors++; $display("FAIL gate_open got=no trig after %0d want=trig", n); end
        checks++; if (rd_addr !== 26'd0) begin errors++; $display("FAIL gate_addr got=%0d want=0", rd_addr); end
        wr_addr = '1;
        for (int k = 0; k < 3; k++) begin
            int ea = m_addr;
            serve(RD_LEN, 1'($urandom_range(0, 1)), a, got);
            checks++; if (!got || a !== 26'(ea)) begin errors++; $display("FAIL clean_addr%0d got=%0d/%0b want=%0d", k, a, got, ea); end
        end
        checks++; if (beat_cnt !== 32'd384) begin errors++; $display("FAIL clean_beats got=%0d want=384", beat_cnt); end
        checks++; if (burst_cnt !== 16'd3) begin errors++; $display("FAIL clean_bursts got=%0d want=3", burst_cnt); end
        checks++; if (err_flag !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err got=%0b/%0d want=0/0", err_flag, err_cnt); end
    endtask

    task automatic test_corrupt();
        logic [25:0] a;
        bit got;
        do_reset();
        corrupt[260] = 32'hDEAD;
        for (int k = 0; k < 3; k++) serve(RD_LEN, 1'b1, a, got);
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL corrupt_cnt got=%0d want=1", err_cnt); end
        checks++; if (first_err_addr !== 26'd260) begin errors++; $display("FAIL corrupt_addr got=%0d want=260", first_err_addr); end
        checks++; if (first_err_data !== 32'hDEAD) begin errors++; $display("FAIL corrupt_data got=%0h want=dead", first_err_data); end
        checks++; if (err_flag !== 1'b1 || burst_cnt !== 16'd3 || beat_cnt !== 32'd384) begin errors++; $display("FAIL corrupt_rest got=%0b/%0d/%0d want=1/3/384", err_flag, burst_cnt, beat_cnt); end
    endtask

    task automatic test_short_burst();
        logic [25:0] a;
        bit got;
        do_reset();
        serve(RD_LEN - 1, 1'($urandom_range(0, 1)), a, got);
        checks++; if (err_flag !== 1'b1 || burst_cnt !== 16'd0) begin errors++; $display("FAIL short_len got=%0b/%0d want=1/0", err_flag, burst_cnt); end
        checks++; if (beat_cnt !== 32'd127) begin errors++; $display("FAIL short_beats got=%0d want=127", beat_cnt); end
        serve(RD_LEN, 1'b0, a, got);
        checks++; if (!got || a !== 26'd256) begin errors++; $display("FAIL short_next got=%0d want=256", a); end
        checks++; if (burst_cnt !== 16'(m_bursts) || err_cnt !== 16'(m_err)) begin errors++; $display("FAIL short_after got=%0d/%0d want=%0d/%0d", burst_cnt, err_cnt, m_bursts, m_err); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        for (int i = 0; i < 50 && !rd_trig; i++) @(negedge clk);
        while (!timeout && n < TMO + 50) begin @(negedge clk); n++; end
        checks++; if (n !== TMO) begin errors++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO); end
        checks++; if (timeout !== 1'b1 || err_flag !== 1'b1) begin errors++; $display("FAIL timeout_flags got=%0b/%0b want=1/1", timeout, err_flag); end
        checks++; if (rd_trig !== 1'b0) begin errors++; $display("FAIL timeout_gap got=trig want=idle"); end
        n = 0;
        while (!rd_trig && n < GAP + 10) begin @(negedge clk); n++; end
        checks++; if (!rd_trig || n < GAP || rd_addr !== 26'd0) begin errors++; $display("FAIL timeout_retry got=%0b after %0d at %0d want=1 after >=%0d at 0", rd_trig, n, rd_addr, GAP); end
    endtask

    task automatic test_wrap();
        logic [25:0] a;
        bit got;
        do_reset();
        for (int k = 0; k < 4; k++) serve(RD_LEN, 1'b1, a, got);
        wr_addr = '0;
        serve(RD_LEN, 1'b1, a, got);
        checks++; if (!got || a !== 26'd0) begin errors++; $display("FAIL wrap_addr got=%0d/%0b want=0", a, got); end
        checks++; if (err_flag !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL wrap_err got=%0b/%0d want=0/0", err_flag, err_cnt); end
        checks++; if (burst_cnt !== 16'd5 || beat_cnt !== 32'd640) begin errors++; $display("FAIL wrap_cnt got=%0d/%0d want=5/640", burst_cnt, beat_cnt); end
        wr_addr = '1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 50 && !rd_trig; i++) @(negedge clk);
        rd_ready = 1; @(negedge clk); rd_ready = 0;
        for (int i = 0; i < 10; i++) begin
            rd_data = 32'(i + 1); rd_data_en = 1; @(negedge clk); rd_data_en = 0;
        end
        rst_n = 0; rd_data = 32'h0; rd_data_en = 1;
        @(negedge clk);
        rst_n = 1;
        checks++; if ({rd_trig, err_flag, err_cnt, burst_cnt, beat_cnt, rd_addr} !== '0) begin errors++; $display("FAIL midrst_zero got=%0h want=0", {rd_trig, err_flag, err_cnt, burst_cnt, beat_cnt, rd_addr}); end
        for (int i = 0; i < 20; i++) begin rd_done = i == 19; @(negedge clk); end
        rd_data_en = 0; rd_done = 0;
        checks++; if (beat_cnt !== 32'd0 || err_cnt !== 16'd0 || err_flag !== 1'b0 || burst_cnt !== 16'd0) begin errors++; $display("FAIL midrst_late got=%0d/%0d/%0b/%0d want=0/0/0/0", beat_cnt, err_cnt, err_flag, burst_cnt); end
        checks++; if (rd_trig !== 1'b1) begin errors++; $display("FAIL midrst_req got=%0b want=1", rd_trig); end
    endtask

    task automatic test_random();
        logic [25:0] a;
        bit got;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int ea = m_addr;
            int n = $urandom_range(0, 3) == 0 ? RD_LEN - int'($urandom_range(1, 3)) : RD_LEN;
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
                int w = m_addr + 2 * int'($urandom_range(0, RD_LEN - 1));
                corrupt[w] = 32'(w / 2 + 1) ^ (32'd1 << $urandom_range(0, 31));
            end
            serve(n, 1'($urandom_range(0, 1)), a, got);
            checks++; if (!got || a !== 26'(ea)) begin errors++; $display("FAIL rand_addr%0d got=%0d want=%0d", k, a, ea); end
        end
        checks++; if (err_cnt !== 16'(m_err) || beat_cnt !== 32'(m_beats)) begin errors++; $display("FAIL rand_cnt got=%0d/%0d want=%0d/%0d", err_cnt, beat_cnt, m_err, m_beats); end
        checks++; if (burst_cnt !== 16'(m_bursts) || err_flag !== m_errflag) begin errors++; $display("FAIL rand_burst got=%0d/%0b want=%0d/%0b", burst_cnt, err_flag, m_bursts, m_errflag); end
        checks++; if (first_err_addr !== m_first_addr || first_err_data !== m_first_data) begin errors++; $display("FAIL rand_first got=%0d/%0h want=%0d/%0h", first_err_addr, first_err_data, m_first_addr, m_first_data); end
    endtask

    initial begin
        test_reset();
        test_gating_clean();
        test_corrupt();
        test_short_burst();
        test_timeout();
        test_wrap();
        test_reset_mid_burst();
        for (int r = 0; r < 3; r++) test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
